cyclic_encoder_7_4: RTL and testbench

Serial-LFSR systematic (7,4) cyclic encoder with generator g(x)=x^3+x+1. It sits directly upstream of the (7,4) cyclic decoder and produces the 7-bit word that drives the decoder's y[6:0] input, high-order term in bit 6. Optional per-word error injection lets benches feed single-bit-error words into the decoder. Valid/ready handshakes on both sides.

---
 rtl/cyclic_encoder_7_4.sv | 110 +++++++++++
 tb/tb_cyclic_encoder_7_4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_encoder_7_4.sv
// Systematic (7,4) cyclic encoder: a 3-bit LFSR divides msg*x^3 by the generator
// one message bit per cycle, then presents {msg, parity} ^ err_mask with valid/ready.
module cyclic_encoder_7_4 #(
    parameter logic [2:0] GPOLY     = 3'b011,
    parameter bit         INJECT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] msg,
    input  logic [6:0] err_mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] y,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [6:0] e_q, e_d;
    logic [2:0] r_q, r_d;
    logic [1:0] k_q, k_d;
    logic [6:0] y_q, y_d;
    logic       out_valid_q, out_valid_d;
    logic       fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= 4'b0;
            e_q         <= 7'b0;
            r_q         <= 3'b0;
            k_q         <= 2'd0;
            y_q         <= 7'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            e_q         <= e_d;
            r_q         <= r_d;
            k_q         <= k_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        e_d         = e_q;
        r_d         = r_q;
        k_d         = k_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        fb          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = msg;
                    e_d     = INJECT_EN ? err_mask : 7'b0;
                    r_d     = 3'b0;
                    k_d     = 2'd3;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // Feedback divider: remainder of msg*x^3 mod g(x), MSB first.
                fb  = m_q[k_q] ^ r_q[2];
                r_d = {r_q[1] ^ (fb & GPOLY[2]),
                       r_q[0] ^ (fb & GPOLY[1]),
                       fb & GPOLY[0]};
                k_d = k_q - 2'd1;
                if (k_q == 2'd0) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // First HOLD cycle registers the word; it then stays put until taken.
                if (!out_valid_q) begin
                    y_d         = {m_q, r_q} ^ e_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_cyclic_encoder_7_4.sv
// Bench for cyclic_encoder_7_4: vector table, exhaustive and random sweeps against a
// polynomial-division model, plus backpressure and reset-abort sequences.
module tb_cyclic_encoder_7_4;

    localparam logic [2:0] GP = 3'b011;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] msg;
    logic [6:0] err_mask;
    logic       out_ready;
    logic       in_ready_a, out_valid_a, busy_a;
    logic       in_ready_b, out_valid_b, busy_b;
    logic [6:0] y_a, y_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cyclic_encoder_7_4 #(.GPOLY(GP), .INJECT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .msg(msg), .err_mask(err_mask), .out_valid(out_valid_a),
        .out_ready(out_ready), .y(y_a), .busy(busy_a)
    );

    cyclic_encoder_7_4 #(.GPOLY(GP), .INJECT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .msg(msg), .err_mask(err_mask), .out_valid(out_valid_b),
        .out_ready(out_ready), .y(y_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Remainder of v(x) divided by x^3 + GP, by plain long division.
    function automatic logic [2:0] poly_rem(input logic [6:0] v);
        logic [6:0] acc;
        logic [6:0] g;
        acc = v;
        g   = {3'b000, 1'b1, GP};
        for (int b = 6; b >= 3; b--) begin
            if (acc[b]) acc = acc ^ (g << (b - 3));
        end
        return acc[2:0];
    endfunction

    function automatic logic [6:0] ref_enc(input logic [3:0] m);
        return {m, poly_rem({m, 3'b000})};
    endfunction

    // Single-error syndrome decoder standing in for the downstream block.
    function automatic logic [6:0] ref_dec(input logic [6:0] r);
        logic [2:0] s;
        logic [6:0] one;
        s = poly_rem(r);
        if (s == 3'b000) return r;
        for (int i = 0; i < 7; i++) begin
            one = 7'b1 << i;
            if (poly_rem(one) == s) return r ^ one;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle and out_ready=1; returns both words.
    task automatic send(input logic [3:0] m, input logic [6:0] e,
                        output logic [6:0] ya, output logic [6:0] yb, output int lat);
        in_valid  = 1'b1;
        msg       = m;
        err_mask  = e;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        msg      = 4'($urandom);
        err_mask = 7'($urandom);
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            tick();
            lat++;
        end
        ya = y_a;
        yb = y_b;
        check("out_valid_b_with_a", {31'b0, out_valid_b}, {31'b0, out_valid_a});
        tick();
        check("in_ready_after_xfer", {31'b0, in_ready_a}, 32'd1);
        check("out_valid_after_xfer", {31'b0, out_valid_a}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] m;
        logic [6:0] e;
        logic [6:0] ya;
        logic [6:0] yb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [6:0] ya, yb, hold_y;
        int         lat;

        vecs[0] = '{4'b0000, 7'b0000000, 7'b0000000, 7'b0000000};
        vecs[1] = '{4'b1000, 7'b0000000, 7'b1000101, 7'b1000101};
        vecs[2] = '{4'b0001, 7'b0000000, 7'b0001011, 7'b0001011};
        vecs[3] = '{4'b1111, 7'b0000000, 7'b1111111, 7'b1111111};
        vecs[4] = '{4'b1000, 7'b0000100, 7'b1000001, 7'b1000101};

        rst = 1'b1; in_valid = 1'b0; msg = 4'b0; err_mask = 7'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_y", {25'b0, y_a}, 32'd0);
        check("rst_y_b", {25'b0, y_b}, 32'd0);
        check("rst_busy_b", {31'b0, busy_b}, 32'd0);
        check("rst_in_ready_b", {31'b0, in_ready_b}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].m, vecs[i].e, ya, yb, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd5);
            check($sformatf("vec%0d_y_inject", i), {25'b0, ya}, {25'b0, vecs[i].ya});
            check($sformatf("vec%0d_y_clean", i), {25'b0, yb}, {25'b0, vecs[i].yb});
            check($sformatf("vec%0d_decoded", i), {25'b0, ref_dec(ya)}, {25'b0, ref_enc(vecs[i].m)});
        end

        for (int m = 0; m < 16; m++) begin
            send(4'(m), 7'b0, ya, yb, lat);
            check($sformatf("sweep%0d_y", m), {25'b0, ya}, {25'b0, ref_enc(4'(m))});
            check($sformatf("sweep%0d_divisible", m), {29'b0, poly_rem(ya)}, 32'd0);
        end

        for (int n = 0; n < 30; n++) begin
            logic [3:0] rm;
            logic [6:0] re;
            rm = 4'($urandom);
            re = 7'($urandom);
            send(rm, re, ya, yb, lat);
            check($sformatf("rand%0d_y_inject", n), {25'b0, ya}, {25'b0, ref_enc(rm) ^ re});
            check($sformatf("rand%0d_y_clean", n), {25'b0, yb}, {25'b0, ref_enc(rm)});
        end

        // Backpressure: word parks in HOLD while input side is toggled.
        in_valid = 1'b1; msg = 4'b1000; err_mask = 7'b0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 32'd5);
        hold_y = y_a;
        check("bp_y", {25'b0, hold_y}, {25'b0, ref_enc(4'b1000)});
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            msg      = 4'($urandom);
            err_mask = 7'($urandom);
            tick();
            check($sformatf("bp%0d_out_valid", c), {31'b0, out_valid_a}, 32'd1);
            check($sformatf("bp%0d_y_stable", c), {25'b0, y_a}, {25'b0, hold_y});
            check($sformatf("bp%0d_in_ready", c), {31'b0, in_ready_a}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", {31'b0, out_valid_a}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready_a}, 32'd1);
        begin
            int extra = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (out_valid_a) extra++;
            end
            check("bp_single_transfer", extra, 32'd0);
        end

        // Reset on the second SHIFT cycle aborts the word.
        in_valid = 1'b1; msg = 4'b1111; err_mask = 7'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready_a}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid_a}, 32'd0);
        check("abort_y", {25'b0, y_a}, 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (out_valid_a) seen++;
            end
            check("abort_never_presented", seen, 32'd0);
        end
        send(4'b0001, 7'b0, ya, yb, lat);
        check("after_abort_y", {25'b0, ya}, 32'h0B);
        check("after_abort_latency", lat, 32'd5);

        // Reset and in_valid together: nothing captured.
        rst = 1'b1; in_valid = 1'b1; msg = 4'b1010;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_vs_valid_busy", {31'b0, busy_a}, 32'd0);
        check("rst_vs_valid_in_ready", {31'b0, in_ready_a}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
